// File: rtl/mesi_plru_cache_ctrl.sv
// mesi_plru_cache_ctrl
//   Per-cache MESI controller with registered processor/snoop responses and a
//   per-set replacement policy. Sits between one L1 tag/state array and the
//   shared snoop bus. Responses appear one cycle after the request is sampled.
//
//   Build option: CACHE_CTRL_TREE_PLRU_EN
//     defined   -> tree pseudo-LRU, ASSOC-1 heap-ordered bits per set
//     undefined -> per-set round-robin pointer advanced on miss fills
module mesi_plru_cache_ctrl #(
  parameter int ASSOC    = 4,
  parameter int NUM_SETS = 16,
  localparam int WAY_W   = $clog2(ASSOC),
  localparam int INDEX_W = $clog2(NUM_SETS)
) (
  input  logic               clk,
  input  logic               rst,
  // processor side
  input  logic               PrRd,
  input  logic               PrWr,
  input  logic [INDEX_W-1:0] Proc_index,
  input  logic               Proc_hit,
  input  logic [WAY_W-1:0]   Proc_way,
  input  logic [1:0]         Current_MESI_state_proc,
  input  logic               Shared,
  // snoop side
  input  logic               BusRd,
  input  logic               BusRdX,
  input  logic               Invalidate,
  input  logic [INDEX_W-1:0] Snoop_index,
  input  logic               Snoop_hit,
  input  logic [WAY_W-1:0]   Snoop_way,
  input  logic [1:0]         Current_MESI_state_snoop,
  // combinational
  output logic [WAY_W-1:0]   LRU_replacement_proc,
  output logic               Proc_stall,
  // registered processor response
  output logic               Proc_rsp_valid,
  output logic [1:0]         Updated_MESI_state_proc,
  output logic [WAY_W-1:0]   Proc_way_out,
  output logic               BusRd_req,
  output logic               BusRdX_req,
  output logic               BusUpgr_req,
  // registered snoop response
  output logic               Snoop_rsp_valid,
  output logic [1:0]         Updated_MESI_state_snoop,
  output logic [WAY_W-1:0]   Snoop_way_out,
  output logic               Flush,
  output logic               Shared_out
);

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_E = 2'b10;
  localparam logic [1:0] ST_M = 2'b11;

  logic             proc_req;
  logic             proc_hit_v;
  logic             proc_acc;
  logic             snoop_v;
  logic             conflict;
  logic [WAY_W-1:0] victim;
  logic [WAY_W-1:0] proc_tgt;

  logic [1:0]       proc_nxt;
  logic             nxt_rd;
  logic             nxt_rdx;
  logic             nxt_upg;
  logic [1:0]       snoop_nxt;
  logic             nxt_flush;
  logic             nxt_shr;

  // Request qualification; requests seen during reset are ignored
  always_comb begin
    proc_req   = (PrRd | PrWr) & ~rst;
    proc_hit_v = Proc_hit & (Current_MESI_state_proc != ST_I);
    // an I-state hit refills its own way; a true miss takes the victim
    proc_tgt   = Proc_hit ? Proc_way : victim;
    snoop_v    = (BusRd | BusRdX | Invalidate) & Snoop_hit &
                 (Current_MESI_state_snoop != ST_I) & ~rst;
    // snoop owns the line when both touch the same set and way
    conflict   = proc_req & snoop_v & (Proc_index == Snoop_index) &
                 (proc_tgt == Snoop_way);
    proc_acc   = proc_req & ~conflict;
  end

  assign Proc_stall           = conflict;
  assign LRU_replacement_proc = victim;

`ifdef CACHE_CTRL_TREE_PLRU_EN
  // bit 0 of each set is unused; node 1 is the root, children of n are 2n, 2n+1
  logic [NUM_SETS-1:0][ASSOC-1:0] plru_q;
  logic [ASSOC-1:0]               plru_upd;
  logic [WAY_W-1:0]               vic_node;
  logic [WAY_W-1:0]               upd_node;
  logic                           vic_b;
  logic                           upd_b;

  // Victim walk: each node bit picks the child to descend into
  always_comb begin
    victim   = '0;
    vic_node = WAY_W'(1);
    vic_b    = 1'b0;
    for (int l = 0; l < WAY_W; l++) begin
      vic_b                = plru_q[Proc_index][vic_node];
      victim[WAY_W-1-l]    = vic_b;
      vic_node             = vic_node << 1;
      vic_node[0]          = vic_b;
    end
  end

  // Touch: every node on the accessed way's path points away from it
  always_comb begin
    plru_upd = plru_q[Proc_index];
    upd_node = WAY_W'(1);
    upd_b    = 1'b0;
    for (int l = 0; l < WAY_W; l++) begin
      upd_b              = proc_tgt[WAY_W-1-l];
      plru_upd[upd_node] = ~upd_b;
      upd_node           = upd_node << 1;
      upd_node[0]        = upd_b;
    end
  end

  // PLRU state; only accepted processor accesses update it
  always_ff @(posedge clk) begin
    if (rst)
      plru_q <= '0;
    else if (proc_acc)
      plru_q[Proc_index] <= plru_upd;
  end
`else
  logic [NUM_SETS-1:0][WAY_W-1:0] rr_q;

  assign victim = rr_q[Proc_index];

  // Round-robin pointer; moves only when a miss fills the pointed-to way
  always_ff @(posedge clk) begin
    if (rst)
      rr_q <= '0;
    else if (proc_acc && !Proc_hit)
      rr_q[Proc_index] <= rr_q[Proc_index] + 1'b1;
  end
`endif

  // Processor-side MESI next state and bus request selection
  always_comb begin
    proc_nxt = ST_I;
    nxt_rd   = 1'b0;
    nxt_rdx  = 1'b0;
    nxt_upg  = 1'b0;
    if (proc_hit_v) begin
      unique case (Current_MESI_state_proc)
        ST_M:    proc_nxt = ST_M;
        ST_E:    proc_nxt = PrWr ? ST_M : ST_E;
        ST_S: begin
          proc_nxt = PrWr ? ST_M : ST_S;
          nxt_upg  = PrWr;
        end
        default: proc_nxt = ST_I;
      endcase
    end else if (PrWr) begin
      proc_nxt = ST_M;
      nxt_rdx  = 1'b1;
    end else begin
      proc_nxt = Shared ? ST_S : ST_E;
      nxt_rd   = 1'b1;
    end
  end

  // Snoop-side MESI next state; BusRdX > BusRd > Invalidate
  always_comb begin
    snoop_nxt = ST_I;
    nxt_flush = 1'b0;
    nxt_shr   = 1'b0;
    if (BusRdX) begin
      snoop_nxt = ST_I;
      nxt_flush = (Current_MESI_state_snoop == ST_M);
    end else if (BusRd) begin
      snoop_nxt = ST_S;
      nxt_flush = (Current_MESI_state_snoop == ST_M);
      nxt_shr   = 1'b1;
    end else begin
      snoop_nxt = ST_I;
    end
  end

  // Registered processor response; idle cycles drive reset values
  always_ff @(posedge clk) begin
    if (rst) begin
      Proc_rsp_valid          <= 1'b0;
      Updated_MESI_state_proc <= ST_I;
      Proc_way_out            <= '0;
      BusRd_req               <= 1'b0;
      BusRdX_req              <= 1'b0;
      BusUpgr_req             <= 1'b0;
    end else begin
      Proc_rsp_valid          <= proc_acc;
      Updated_MESI_state_proc <= proc_acc ? proc_nxt : ST_I;
      Proc_way_out            <= proc_acc ? proc_tgt : '0;
      BusRd_req               <= proc_acc & nxt_rd;
      BusRdX_req              <= proc_acc & nxt_rdx;
      BusUpgr_req             <= proc_acc & nxt_upg;
    end
  end

  // Registered snoop response
  always_ff @(posedge clk) begin
    if (rst) begin
      Snoop_rsp_valid          <= 1'b0;
      Updated_MESI_state_snoop <= ST_I;
      Snoop_way_out            <= '0;
      Flush                    <= 1'b0;
      Shared_out               <= 1'b0;
    end else begin
      Snoop_rsp_valid          <= snoop_v;
      Updated_MESI_state_snoop <= snoop_v ? snoop_nxt : ST_I;
      Snoop_way_out            <= snoop_v ? Snoop_way : '0;
      Flush                    <= snoop_v & nxt_flush;
      Shared_out               <= snoop_v & nxt_shr;
    end
  end

endmodule

// File: tb/tb_mesi_plru_cache_ctrl.sv
// Scoreboard bench for mesi_plru_cache_ctrl: the stimulus process computes
// expected responses from a set-level reference model and queues them; a
// monitor pops and compares whenever a response is due or presented.
module tb_mesi_plru_cache_ctrl;
  localparam int ASSOC    = 4;
  localparam int NUM_SETS = 16;
  localparam int WAY_W    = $clog2(ASSOC);
  localparam int INDEX_W  = $clog2(NUM_SETS);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic PrRd = 0, PrWr = 0, Proc_hit = 0, Shared = 0;
  logic [INDEX_W-1:0] Proc_index = '0, Snoop_index = '0;
  logic [WAY_W-1:0]   Proc_way = '0, Snoop_way = '0;
  logic [1:0]         Current_MESI_state_proc = '0, Current_MESI_state_snoop = '0;
  logic BusRd = 0, BusRdX = 0, Invalidate = 0, Snoop_hit = 0;

  logic [WAY_W-1:0] LRU_replacement_proc, Proc_way_out, Snoop_way_out;
  logic Proc_stall, Proc_rsp_valid, BusRd_req, BusRdX_req, BusUpgr_req;
  logic Snoop_rsp_valid, Flush, Shared_out;
  logic [1:0] Updated_MESI_state_proc, Updated_MESI_state_snoop;

  mesi_plru_cache_ctrl #(.ASSOC(ASSOC), .NUM_SETS(NUM_SETS)) dut (
    .clk(clk), .rst(rst),
    .PrRd(PrRd), .PrWr(PrWr), .Proc_index(Proc_index), .Proc_hit(Proc_hit),
    .Proc_way(Proc_way), .Current_MESI_state_proc(Current_MESI_state_proc),
    .Shared(Shared),
    .BusRd(BusRd), .BusRdX(BusRdX), .Invalidate(Invalidate),
    .Snoop_index(Snoop_index), .Snoop_hit(Snoop_hit), .Snoop_way(Snoop_way),
    .Current_MESI_state_snoop(Current_MESI_state_snoop),
    .LRU_replacement_proc(LRU_replacement_proc), .Proc_stall(Proc_stall),
    .Proc_rsp_valid(Proc_rsp_valid), .Updated_MESI_state_proc(Updated_MESI_state_proc),
    .Proc_way_out(Proc_way_out), .BusRd_req(BusRd_req), .BusRdX_req(BusRdX_req),
    .BusUpgr_req(BusUpgr_req),
    .Snoop_rsp_valid(Snoop_rsp_valid), .Updated_MESI_state_snoop(Updated_MESI_state_snoop),
    .Snoop_way_out(Snoop_way_out), .Flush(Flush), .Shared_out(Shared_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  typedef struct { int due; int st; int way; bit rd; bit rdx; bit upg; } prsp_t;
  typedef struct { int due; int st; int way; bit flush; bit shr; } srsp_t;
  prsp_t pq[$];
  srsp_t sq[$];

  // ---------------- reference model ----------------
  // MESI codes: I=0 S=1 E=2 M=3
  bit plru_m[NUM_SETS][ASSOC];
  int ptr_m[NUM_SETS];

  function automatic int victim_of(int s);
`ifdef CACHE_CTRL_TREE_PLRU_EN
    int n = 1;
    int v = 0;
    for (int l = 0; l < WAY_W; l++) begin
      int b = int'(plru_m[s][n]);
      v = v * 2 + b;
      n = 2 * n + b;
    end
    return v;
`else
    return ptr_m[s];
`endif
  endfunction

  task automatic model_clear();
    for (int s = 0; s < NUM_SETS; s++) begin
      ptr_m[s] = 0;
      for (int k = 0; k < ASSOC; k++) plru_m[s][k] = 1'b0;
    end
  endtask

  task automatic model_touch(int s, int w, bit miss);
`ifdef CACHE_CTRL_TREE_PLRU_EN
    int n = 1;
    for (int l = WAY_W - 1; l >= 0; l--) begin
      int b = (w >> l) & 1;
      plru_m[s][n] = (b == 0);
      n = 2 * n + b;
    end
`else
    if (miss) ptr_m[s] = (ptr_m[s] + 1) % ASSOC;
`endif
  endtask

  // One cycle: check combinational outputs mid-cycle, queue expected
  // registered responses for the next cycle, advance the model.
  task automatic step();
    int vic, tway, st, sst;
    bit preq, sv, conf;
    prsp_t p;
    srsp_t q;
    @(negedge clk);
    vic  = victim_of(int'(Proc_index));
    chk("victim", 32'(LRU_replacement_proc), vic);
    preq = (PrRd || PrWr) && !rst;
    sst  = int'(Current_MESI_state_snoop);
    sv   = (BusRd || BusRdX || Invalidate) && Snoop_hit && sst != 0 && !rst;
    tway = Proc_hit ? int'(Proc_way) : vic;
    conf = preq && sv && Proc_index == Snoop_index && tway == int'(Snoop_way);
    chk("stall", 32'(Proc_stall), 32'(conf));
    if (rst) begin
      model_clear();
    end else begin
      if (preq && !conf) begin
        st = int'(Current_MESI_state_proc);
        p = '{due: cyc + 1, st: 0, way: tway, rd: 0, rdx: 0, upg: 0};
        if (Proc_hit && st != 0) begin
          p.st  = PrWr ? 3 : st;
          p.upg = PrWr && st == 1;
        end else if (PrWr) begin
          p.st = 3; p.rdx = 1;
        end else begin
          p.st = Shared ? 1 : 2; p.rd = 1;
        end
        pq.push_back(p);
        model_touch(int'(Proc_index), tway, !Proc_hit);
      end
      if (sv) begin
        q = '{due: cyc + 1, st: 0, way: int'(Snoop_way), flush: 0, shr: 0};
        if (BusRdX)     begin q.st = 0; q.flush = (sst == 3); end
        else if (BusRd) begin q.st = 1; q.flush = (sst == 3); q.shr = 1; end
        else            q.st = 0;
        sq.push_back(q);
      end
    end
    @(posedge clk); #1;
  endtask

  // ---------------- monitor ----------------
  prsp_t pe;
  srsp_t se;
  always @(negedge clk) begin
    while (pq.size() > 0 && pq[0].due < cyc) begin
      pe = pq.pop_front();
      chk("proc_rsp_missing", 0, 1);
    end
    if (pq.size() > 0 && pq[0].due == cyc) begin
      pe = pq.pop_front();
      chk("proc_valid", 32'(Proc_rsp_valid), 1);
      chk("proc_state", 32'(Updated_MESI_state_proc), pe.st);
      chk("proc_way",   32'(Proc_way_out), pe.way);
      chk("proc_bus",   {29'd0, BusRd_req, BusRdX_req, BusUpgr_req},
                        {29'd0, pe.rd, pe.rdx, pe.upg});
    end else begin
      chk("proc_idle", {28'd0, Proc_rsp_valid, BusRd_req, BusRdX_req, BusUpgr_req}, 0);
    end
    while (sq.size() > 0 && sq[0].due < cyc) begin
      se = sq.pop_front();
      chk("snoop_rsp_missing", 0, 1);
    end
    if (sq.size() > 0 && sq[0].due == cyc) begin
      se = sq.pop_front();
      chk("snoop_valid", 32'(Snoop_rsp_valid), 1);
      chk("snoop_state", 32'(Updated_MESI_state_snoop), se.st);
      chk("snoop_way",   32'(Snoop_way_out), se.way);
      chk("snoop_fs",    {30'd0, Flush, Shared_out}, {30'd0, se.flush, se.shr});
    end else begin
      chk("snoop_idle", {29'd0, Snoop_rsp_valid, Flush, Shared_out}, 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(int idx);
    PrRd = 0; PrWr = 0; Proc_hit = 0; Shared = 0;
    Proc_index = INDEX_W'(idx); Proc_way = '0; Current_MESI_state_proc = '0;
    BusRd = 0; BusRdX = 0; Invalidate = 0; Snoop_hit = 0;
    Snoop_index = '0; Snoop_way = '0; Current_MESI_state_snoop = '0;
  endtask

  task automatic drv_p(bit rd, bit wr, int idx, bit hit, int way, int st, bit shr);
    PrRd = rd; PrWr = wr; Proc_index = INDEX_W'(idx); Proc_hit = hit;
    Proc_way = WAY_W'(way); Current_MESI_state_proc = 2'(st); Shared = shr;
  endtask

  task automatic drv_s(bit rd, bit rdx, bit inv, int idx, bit hit, int way, int st);
    BusRd = rd; BusRdX = rdx; Invalidate = inv; Snoop_index = INDEX_W'(idx);
    Snoop_hit = hit; Snoop_way = WAY_W'(way); Current_MESI_state_snoop = 2'(st);
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({Proc_rsp_valid, Updated_MESI_state_proc, Proc_way_out,
                BusRd_req, BusRdX_req, BusUpgr_req, Snoop_rsp_valid,
                Updated_MESI_state_snoop, Snoop_way_out, Flush, Shared_out});
  endfunction

  initial begin
    model_clear();
    // reset with requests present: they must be ignored
    @(posedge clk); #1;
    idle(3); drv_p(1, 0, 3, 0, 0, 0, 0); drv_s(0, 1, 0, 3, 1, 0, 3);
    step(); step();
    chk("reset_outputs", all_outs(), 0);
    rst = 0;

    // read miss set 3, Shared=0 -> E, way 0, BusRd
    idle(3); drv_p(1, 0, 3, 0, 0, 0, 0); step();
    idle(3);
`ifdef CACHE_CTRL_TREE_PLRU_EN
    chk("set3_victim", 32'(LRU_replacement_proc), 2);
`else
    chk("set3_victim", 32'(LRU_replacement_proc), 1);
`endif
    step();

    // write hit S -> M with BusUpgr; read hit E stays E
    idle(1); drv_p(0, 1, 1, 1, 1, 1, 0); step();
    idle(1); drv_p(1, 0, 1, 1, 1, 2, 0); step();

    // snoop BusRd on M -> S, Flush, Shared_out; BusRdX on S -> I, no Flush
    idle(4); drv_s(1, 0, 0, 4, 1, 2, 3); step();
    idle(4); drv_s(0, 1, 0, 4, 1, 0, 1); step();

    // same set and way conflict: snoop wins, processor stalls
    idle(7); drv_p(0, 1, 7, 1, 1, 1, 0); drv_s(0, 1, 0, 7, 1, 1, 1); step();
    idle(7); drv_p(0, 1, 7, 0, 0, 0, 0); step();

    // different ways of the same set proceed together
    idle(8); drv_p(1, 0, 8, 1, 0, 2, 0); drv_s(1, 0, 0, 8, 1, 3, 2); step();

    // hits on set 5 to ways 0,2,1,3
    idle(5); drv_p(1, 0, 5, 1, 0, 2, 0); step();
    idle(5); drv_p(1, 0, 5, 1, 2, 2, 0); step();
    idle(5); drv_p(0, 1, 5, 1, 1, 3, 0); step();
    idle(5); drv_p(1, 0, 5, 1, 3, 1, 0); step();
    idle(5);
    chk("set5_victim", 32'(LRU_replacement_proc), 0);
    step();

    // five misses in set 6
    for (int k = 0; k < 5; k++) begin
      idle(6); drv_p(k[0], !k[0], 6, 0, 0, 0, k[1]); step();
    end

    // reset one cycle after a request (reset-time request ignored)
    idle(2); drv_p(1, 0, 2, 0, 0, 0, 1); step();
    rst = 1; idle(2); drv_p(0, 1, 2, 0, 0, 0, 0); drv_s(1, 0, 0, 2, 1, 1, 3); step();
    rst = 0; idle(2);
    chk("midrst_outputs", all_outs(), 0);
    for (int s = 0; s < NUM_SETS; s++) begin
      idle(s); step();
    end

    // randomized traffic on a few sets to provoke conflicts
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      drv_p($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
            int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
            int'($urandom_range(0, ASSOC - 1)), int'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1);
      drv_s($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, int'($urandom_range(0, 3)),
            $urandom_range(0, 3) != 0, int'($urandom_range(0, ASSOC - 1)),
            int'($urandom_range(0, 3)));
      step();
    end
    rst = 0;
    idle(0);
    step(); step(); step();
    chk("queues_drained", 32'(pq.size() + sq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
